pkt_req_arb: RTL and testbench
==============================

PKT_REQ_ARB -- requirements
Module: pkt_req_arb

Interface
REQ-001 Parameters SHALL be:
- REQ_WID, 38: request message width.
- DAT_WID, 256: packet data width.
- MSG_WID, 14: packet sideband width.
- EOP_POS, 1: bit index of end-of-packet in the packet message.
- ORD_DEPTH, 8: maximum number of outstanding requests (power of 2, at least 2).

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous active-high reset.
- req_vld, in, 2: request valid; bit 0 is the RX edit engine, bit 1 is the TX edit engine.
- req_rdy, out, 2: request accepted, per requester.
- req_msg, in, 2*REQ_WID: request messages; requester i uses [i*REQ_WID +: REQ_WID].
- pkt_req_vld, out, 1: request valid toward packet memory.
- pkt_req_rdy, in, 1: packet memory accepts the request.
- pkt_req_msg, out, REQ_WID: granted request message.
- in_pkt_vld, in, 1: read-data beat valid from packet memory.
- in_pkt_rdy, out, 1: read-data beat accepted.
- in_pkt_dat, in, DAT_WID: read data.
- in_pkt_msg, in, MSG_WID: read sideband; bit EOP_POS marks end of packet.
- out_pkt_vld, out, 2: routed beat valid, per requester.
- out_pkt_rdy, in, 2: per-requester ready.
- out_pkt_dat, out, DAT_WID: broadcast data.
- out_pkt_msg, out, MSG_WID: broadcast sideband.
- ord_cnt_used, out, clog2(ORD_DEPTH)+1: number of outstanding requests.
- dbg_sig, out, 32: debug counters and error flag.

Function
REQ-003 Request output stage SHALL be a single register (pkt_req_vld/pkt_req_msg); it SHALL be free when pkt_req_vld=0 or pkt_req_rdy=1.
REQ-004 A grant SHALL occur only when the output stage is free, at least one req_vld is set, and the registered ord_cnt_used < ORD_DEPTH.
REQ-005 A pop in the same cycle SHALL NOT enable a grant in that cycle.
REQ-006 Arbitration SHALL be 2-way round-robin on the last_grant pointer:
- If both req_vld bits are set, grant the requester other than last_grant.
- If only one is set, grant that one.
REQ-007 req_rdy[i] SHALL be 1 only in the grant cycle for i, driven combinationally from registered state and req_vld, and SHALL never be 1 for both requesters.
REQ-008 On a grant to i, in the next cycle:
- pkt_req_msg SHALL hold req_msg slice i and pkt_req_vld SHALL be 1 (1-cycle latency).
- last_grant SHALL be i.
- id i SHALL be pushed into the order FIFO.
REQ-009 pkt_req_vld and pkt_req_msg SHALL stay stable while pkt_req_rdy=0; with no new grant, pkt_req_vld SHALL clear after a handshake.
REQ-010 Response routing SHALL be combinational (zero latency), with h = head id of the order FIFO:
- out_pkt_vld[h] = in_pkt_vld AND FIFO non-empty; the other bit SHALL be 0.
- in_pkt_rdy = out_pkt_rdy[h] AND FIFO non-empty.
- out_pkt_dat and out_pkt_msg SHALL pass in_pkt_dat and in_pkt_msg through.
- out_pkt_rdy of the non-head requester SHALL be ignored.
REQ-011 The FIFO head SHALL pop on a beat handshake (in_pkt_vld AND in_pkt_rdy) with in_pkt_msg[EOP_POS]=1. Non-EOP beats SHALL NOT pop.
REQ-012 ord_cnt_used SHALL update as follows:
- +1 on push only.
- -1 on pop only.
- Unchanged on simultaneous push and pop.
- It SHALL never exceed ORD_DEPTH or go below 0.
REQ-013 If in_pkt_vld=1 while the FIFO is empty:
- in_pkt_rdy SHALL be 0.
- Sticky error dbg_sig[31] SHALL set and stay set until rst.
REQ-014 dbg_sig fields SHALL be:
- [7:0]: grants to requester 0, wrapping mod 256.
- [15:8]: grants to requester 1, wrapping mod 256.
- [23:16]: EOP pops, wrapping mod 256.
- [30:24]: 0.
- [31]: error flag.

Reset
REQ-015 While rst=1, all of the following SHALL be 0 and last_grant SHALL be 1, so requester 0 wins first:
- pkt_req_vld and pkt_req_msg.
- ord_cnt_used and the FIFO pointers.
- All dbg_sig counters and the error flag.
- Every output derived from state.
REQ-016 A reset during operation SHALL discard outstanding ids and any pending request. Later read-data beats SHALL then be handled per REQ-013.

Verification
REQ-017 Single request, 3-beat response:
- Stimulus: req_vld=01, pkt_req_rdy=1.
- Response: req_rdy=01 in the same cycle; next cycle pkt_req_vld=1 with msg equal to slice 0 and ord_cnt_used=1.
- A 3-beat response with EOP on beat 3 drives out_pkt_vld=01 for 3 beats; ord_cnt_used=0 after beat 3.
REQ-018 Alternation:
- Stimulus: req_vld=11 held, pkt_req_rdy=1.
- Response: grants alternate 0,1,0,1; dbg_sig[7:0]=dbg_sig[15:8]=2 after 4 grants.
REQ-019 Back-pressure:
- Stimulus: pkt_req_rdy=0 for 5 cycles after a grant.
- Response: pkt_req_msg stable, req_rdy=00 for those 5 cycles; grant resumes the cycle pkt_req_rdy=1.
REQ-020 Full FIFO:
- Stimulus: 8 grants with no responses.
- Response: ord_cnt_used=8 and req_rdy=00.
- One EOP beat then gives ord_cnt_used=7 and a grant the following cycle.
REQ-021 In-order routing:
- Stimulus: grants 0 then 1; out_pkt_rdy=10.
- Response: in_pkt_rdy=0 (stalled on head 0).
- Then out_pkt_rdy=01: beats route to port 0 until EOP, then to port 1.
REQ-022 Spurious read data:
- Stimulus: in_pkt_vld=1 with ord_cnt_used=0.
- Response: in_pkt_rdy=0 and dbg_sig[31]=1, which persists until rst.

Source files
------------

// File: rtl/pkt_req_arb.sv
// Two-requester packet-memory read arbiter.
// Round-robin grants into a single registered request stage, records the granted
// id in an order FIFO, and routes read-data beats back to the FIFO head until EOP.
module pkt_req_arb #(
    parameter int unsigned REQ_WID   = 38,
    parameter int unsigned DAT_WID   = 256,
    parameter int unsigned MSG_WID   = 14,
    parameter int unsigned EOP_POS   = 1,
    parameter int unsigned ORD_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req_vld,
    output logic [1:0]                   req_rdy,
    input  logic [2*REQ_WID-1:0]         req_msg,
    output logic                         pkt_req_vld,
    input  logic                         pkt_req_rdy,
    output logic [REQ_WID-1:0]           pkt_req_msg,
    input  logic                         in_pkt_vld,
    output logic                         in_pkt_rdy,
    input  logic [DAT_WID-1:0]           in_pkt_dat,
    input  logic [MSG_WID-1:0]           in_pkt_msg,
    output logic [1:0]                   out_pkt_vld,
    input  logic [1:0]                   out_pkt_rdy,
    output logic [DAT_WID-1:0]           out_pkt_dat,
    output logic [MSG_WID-1:0]           out_pkt_msg,
    output logic [$clog2(ORD_DEPTH):0]   ord_cnt_used,
    output logic [31:0]                  dbg_sig
);

    localparam int unsigned PTR_W = $clog2(ORD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic                 pkt_req_vld_q, pkt_req_vld_d;
    logic [REQ_WID-1:0]   pkt_req_msg_q, pkt_req_msg_d;
    logic                 last_grant_q, last_grant_d;
    logic [ORD_DEPTH-1:0] ord_id_q, ord_id_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           gnt0_cnt_q, gnt0_cnt_d;
    logic [7:0]           gnt1_cnt_q, gnt1_cnt_d;
    logic [7:0]           eop_cnt_q, eop_cnt_d;
    logic                 err_q, err_d;

    logic stage_free_c;
    logic fifo_ne_c;
    logic head_c;
    logic gnt_ok_c;
    logic gnt_id_c;
    logic pop_c;

    // Grant decision and response routing, all from registered state
    always_comb begin
        stage_free_c = !pkt_req_vld_q || pkt_req_rdy;
        fifo_ne_c    = (cnt_q != '0);
        head_c       = ord_id_q[rd_ptr_q];
        gnt_ok_c     = stage_free_c && (|req_vld) && (cnt_q < CNT_W'(ORD_DEPTH));
        gnt_id_c     = (&req_vld) ? ~last_grant_q : req_vld[1];

        req_rdy      = 2'b00;
        if (gnt_ok_c) begin
            req_rdy = gnt_id_c ? 2'b10 : 2'b01;
        end

        out_pkt_vld  = 2'b00;
        if (in_pkt_vld && fifo_ne_c) begin
            out_pkt_vld = head_c ? 2'b10 : 2'b01;
        end
        in_pkt_rdy   = fifo_ne_c && out_pkt_rdy[head_c];
        out_pkt_dat  = in_pkt_dat;
        out_pkt_msg  = in_pkt_msg;
        pop_c        = in_pkt_vld && in_pkt_rdy && in_pkt_msg[EOP_POS];
    end

    // Next-state for request stage, order FIFO and debug counters
    always_comb begin
        pkt_req_vld_d = pkt_req_vld_q;
        pkt_req_msg_d = pkt_req_msg_q;
        last_grant_d  = last_grant_q;
        ord_id_d      = ord_id_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        gnt0_cnt_d    = gnt0_cnt_q;
        gnt1_cnt_d    = gnt1_cnt_q;
        eop_cnt_d     = eop_cnt_q;
        err_d         = err_q | (in_pkt_vld && !fifo_ne_c);

        if (pkt_req_rdy) begin
            pkt_req_vld_d = 1'b0;
        end

        if (gnt_ok_c) begin
            pkt_req_vld_d      = 1'b1;
            pkt_req_msg_d      = gnt_id_c ? req_msg[REQ_WID +: REQ_WID] : req_msg[0 +: REQ_WID];
            last_grant_d       = gnt_id_c;
            ord_id_d[wr_ptr_q] = gnt_id_c;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
            if (gnt_id_c) begin
                gnt1_cnt_d = gnt1_cnt_q + 8'd1;
            end else begin
                gnt0_cnt_d = gnt0_cnt_q + 8'd1;
            end
        end

        if (pop_c) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            eop_cnt_d = eop_cnt_q + 8'd1;
        end

        case ({gnt_ok_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset leaves requester 0 as the first winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_req_vld_q <= 1'b0;
            pkt_req_msg_q <= '0;
            last_grant_q  <= 1'b1;
            ord_id_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            gnt0_cnt_q    <= '0;
            gnt1_cnt_q    <= '0;
            eop_cnt_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            pkt_req_vld_q <= pkt_req_vld_d;
            pkt_req_msg_q <= pkt_req_msg_d;
            last_grant_q  <= last_grant_d;
            ord_id_q      <= ord_id_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            gnt0_cnt_q    <= gnt0_cnt_d;
            gnt1_cnt_q    <= gnt1_cnt_d;
            eop_cnt_q     <= eop_cnt_d;
            err_q         <= err_d;
        end
    end

    assign pkt_req_vld  = pkt_req_vld_q;
    assign pkt_req_msg  = pkt_req_msg_q;
    assign ord_cnt_used = cnt_q;
    assign dbg_sig      = {err_q, 7'd0, eop_cnt_q, gnt1_cnt_q, gnt0_cnt_q};

endmodule

// File: tb/tb_pkt_req_arb.sv
// Bench for pkt_req_arb: directed scenarios plus randomized traffic, all checked
// by a queue-based reference model in a negedge monitor.
module tb_pkt_req_arb;

    localparam int unsigned REQ_WID   = 38;
    localparam int unsigned DAT_WID   = 256;
    localparam int unsigned MSG_WID   = 14;
    localparam int unsigned EOP_POS   = 1;
    localparam int unsigned ORD_DEPTH = 8;
    localparam int unsigned RMW       = 2 * REQ_WID;
    localparam int unsigned CW        = $clog2(ORD_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req_vld = '0;
    logic [1:0]           req_rdy;
    logic [RMW-1:0]       req_msg = '0;
    logic                 pkt_req_vld;
    logic                 pkt_req_rdy = 1'b0;
    logic [REQ_WID-1:0]   pkt_req_msg;
    logic                 in_pkt_vld = 1'b0;
    logic                 in_pkt_rdy;
    logic [DAT_WID-1:0]   in_pkt_dat = '0;
    logic [MSG_WID-1:0]   in_pkt_msg = '0;
    logic [1:0]           out_pkt_vld;
    logic [1:0]           out_pkt_rdy = '0;
    logic [DAT_WID-1:0]   out_pkt_dat;
    logic [MSG_WID-1:0]   out_pkt_msg;
    logic [CW-1:0]        ord_cnt_used;
    logic [31:0]          dbg_sig;

    pkt_req_arb #(
        .REQ_WID(REQ_WID), .DAT_WID(DAT_WID), .MSG_WID(MSG_WID),
        .EOP_POS(EOP_POS), .ORD_DEPTH(ORD_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_msg(req_msg),
        .pkt_req_vld(pkt_req_vld), .pkt_req_rdy(pkt_req_rdy), .pkt_req_msg(pkt_req_msg),
        .in_pkt_vld(in_pkt_vld), .in_pkt_rdy(in_pkt_rdy),
        .in_pkt_dat(in_pkt_dat), .in_pkt_msg(in_pkt_msg),
        .out_pkt_vld(out_pkt_vld), .out_pkt_rdy(out_pkt_rdy),
        .out_pkt_dat(out_pkt_dat), .out_pkt_msg(out_pkt_msg),
        .ord_cnt_used(ord_cnt_used), .dbg_sig(dbg_sig)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MSG_WID-1:0] mk_msg(input bit eop);
        logic [MSG_WID-1:0] m;
        m = MSG_WID'($urandom());
        m[EOP_POS] = eop;
        return m;
    endfunction

    function automatic logic [DAT_WID-1:0] rnd_dat();
        logic [DAT_WID-1:0] d;
        for (int i = 0; i < int'(DAT_WID / 32); i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [RMW-1:0] rnd_req();
        return RMW'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Reference model: arbitration pointer, occupied stage flag, order queue, counters
    int                 m_last;
    bit                 m_stg;
    int                 ord_q[$];
    logic [REQ_WID-1:0] exp_msg_q[$];
    int                 m_g0, m_g1, m_eop;
    bit                 m_err;
    bit                 e_gnt;
    int                 e_gid, e_sz, e_head;
    logic [1:0]         e_rdy, e_ovld;
    logic               e_irdy;

    // Monitor: compares DUT against the model, then advances the model one clock
    always @(negedge clk) begin
        if (rst) begin
            m_last = 1; m_stg = 0; m_g0 = 0; m_g1 = 0; m_eop = 0; m_err = 0;
            ord_q.delete();
            exp_msg_q.delete();
            chk("rst_pkt_req_vld", 256'(pkt_req_vld), 256'(0));
            chk("rst_pkt_req_msg", 256'(pkt_req_msg), 256'(0));
            chk("rst_ord_cnt", 256'(ord_cnt_used), 256'(0));
            chk("rst_dbg_sig", 256'(dbg_sig), 256'(0));
            chk("rst_out_pkt_vld", 256'(out_pkt_vld), 256'(0));
            chk("rst_in_pkt_rdy", 256'(in_pkt_rdy), 256'(0));
        end else begin
            e_sz  = ord_q.size();
            e_gnt = (!m_stg || pkt_req_rdy) && (req_vld != 2'b00) && (e_sz < int'(ORD_DEPTH));
            e_gid = (req_vld == 2'b11) ? (1 - m_last) : (req_vld[1] ? 1 : 0);
            e_rdy = e_gnt ? 2'(1 << e_gid) : 2'b00;
            chk("req_rdy", 256'(req_rdy), 256'(e_rdy));
            chk("pkt_req_vld", 256'(pkt_req_vld), 256'(m_stg));
            chk("ord_cnt_used", 256'(ord_cnt_used), 256'(e_sz));
            chk("dbg_sig", 256'(dbg_sig), 256'({m_err, 7'd0, 8'(m_eop), 8'(m_g1), 8'(m_g0)}));

            e_head = (e_sz > 0) ? ord_q[0] : 0;
            e_ovld = (e_sz > 0 && in_pkt_vld) ? 2'(1 << e_head) : 2'b00;
            e_irdy = (e_sz > 0) ? out_pkt_rdy[e_head] : 1'b0;
            chk("out_pkt_vld", 256'(out_pkt_vld), 256'(e_ovld));
            chk("in_pkt_rdy", 256'(in_pkt_rdy), 256'(e_irdy));
            if (e_ovld != 2'b00) begin
                chk("out_pkt_dat", out_pkt_dat, in_pkt_dat);
                chk("out_pkt_msg", 256'(out_pkt_msg), 256'(in_pkt_msg));
            end

            // Scoreboard: each request-stage handshake retires the oldest expected message
            if (m_stg && pkt_req_rdy) begin
                chk("pkt_req_msg", 256'(pkt_req_msg), 256'(exp_msg_q.pop_front()));
                m_stg = 0;
            end

            if (in_pkt_vld && e_sz == 0) m_err = 1;
            if (e_sz > 0 && in_pkt_vld && e_irdy && in_pkt_msg[EOP_POS]) begin
                void'(ord_q.pop_front());
                m_eop++;
            end
            if (e_gnt) begin
                exp_msg_q.push_back(e_gid == 1 ? req_msg[REQ_WID +: REQ_WID] : req_msg[0 +: REQ_WID]);
                m_stg  = 1;
                m_last = e_gid;
                ord_q.push_back(e_gid);
                if (e_gid == 1) m_g1++; else m_g0++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_vld = '0; pkt_req_rdy = 1'b0; in_pkt_vld = 1'b0;
        in_pkt_msg = '0; out_pkt_rdy = '0;
    endtask

    task automatic do_reset();
        cyc(); rst = 1'b1; idle();
        cyc(); cyc(); rst = 1'b0;
    endtask

    logic [RMW-1:0] rmsg;
    int             in_pct;

    initial begin
        idle();
        do_reset();

        // Single request, 3-beat response
        rmsg = rnd_req(); req_msg = rmsg; req_vld = 2'b01; pkt_req_rdy = 1'b1;
        @(negedge clk); chk("t17_req_rdy", 256'(req_rdy), 256'(2'b01));
        cyc(); req_vld = 2'b00;
        @(negedge clk);
        chk("t17_pkt_req_vld", 256'(pkt_req_vld), 256'(1));
        chk("t17_pkt_req_msg", 256'(pkt_req_msg), 256'(rmsg[REQ_WID-1:0]));
        chk("t17_cnt", 256'(ord_cnt_used), 256'(1));
        for (int b = 0; b < 3; b++) begin
            cyc(); in_pkt_vld = 1'b1; out_pkt_rdy = 2'b11;
            in_pkt_msg = mk_msg(b == 2); in_pkt_dat = rnd_dat();
            @(negedge clk); chk("t17_out_vld", 256'(out_pkt_vld), 256'(2'b01));
        end
        cyc(); in_pkt_vld = 1'b0;
        @(negedge clk); chk("t17_cnt_end", 256'(ord_cnt_used), 256'(0));

        // Alternation with both requesters held
        do_reset();
        req_vld = 2'b11; pkt_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_msg = rnd_req();
            @(negedge clk); chk("t18_req_rdy", 256'(req_rdy), 256'((i % 2 == 0) ? 2'b01 : 2'b10));
            cyc();
        end
        req_vld = 2'b00;
        @(negedge clk);
        chk("t18_gnt0", 256'(dbg_sig[7:0]), 256'(2));
        chk("t18_gnt1", 256'(dbg_sig[15:8]), 256'(2));

        // Back-pressure on the request stage
        do_reset();
        rmsg = rnd_req(); req_msg = rmsg; req_vld = 2'b01; pkt_req_rdy = 1'b0;
        @(negedge clk); chk("t19_first", 256'(req_rdy), 256'(2'b01));
        cyc(); req_vld = 2'b11; req_msg = rnd_req();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t19_req_rdy", 256'(req_rdy), 256'(2'b00));
            chk("t19_msg_hold", 256'(pkt_req_msg), 256'(rmsg[REQ_WID-1:0]));
            cyc();
        end
        pkt_req_rdy = 1'b1;
        @(negedge clk); chk("t19_resume", 256'(req_rdy), 256'(2'b10));
        cyc(); req_vld = 2'b00;

        // Full order FIFO
        do_reset();
        req_vld = 2'b01; pkt_req_rdy = 1'b1;
        for (int i = 0; i < int'(ORD_DEPTH); i++) begin
            req_msg = rnd_req();
            @(negedge clk); chk("t20_grant", 256'(req_rdy), 256'(2'b01));
            cyc();
        end
        @(negedge clk);
        chk("t20_cnt_full", 256'(ord_cnt_used), 256'(ORD_DEPTH));
        chk("t20_blocked", 256'(req_rdy), 256'(2'b00));
        cyc(); in_pkt_vld = 1'b1; in_pkt_msg = mk_msg(1'b1); out_pkt_rdy = 2'b11;
        @(negedge clk);
        chk("t20_pop_no_gnt", 256'(req_rdy), 256'(2'b00));
        chk("t20_in_rdy", 256'(in_pkt_rdy), 256'(1));
        cyc(); in_pkt_vld = 1'b0;
        @(negedge clk);
        chk("t20_cnt_after", 256'(ord_cnt_used), 256'(ORD_DEPTH - 1));
        chk("t20_regrant", 256'(req_rdy), 256'(2'b01));
        cyc(); req_vld = 2'b00;

        // In-order routing with head stall
        do_reset();
        pkt_req_rdy = 1'b1; req_vld = 2'b01; req_msg = rnd_req();
        cyc(); req_vld = 2'b10; req_msg = rnd_req();
        cyc(); req_vld = 2'b00; out_pkt_rdy = 2'b10; in_pkt_vld = 1'b1; in_pkt_msg = mk_msg(1'b0);
        @(negedge clk);
        chk("t21_stall", 256'(in_pkt_rdy), 256'(0));
        chk("t21_stall_vld", 256'(out_pkt_vld), 256'(2'b01));
        cyc(); out_pkt_rdy = 2'b01; in_pkt_dat = rnd_dat();
        @(negedge clk);
        chk("t21_p0_vld", 256'(out_pkt_vld), 256'(2'b01));
        chk("t21_p0_rdy", 256'(in_pkt_rdy), 256'(1));
        cyc(); in_pkt_msg = mk_msg(1'b1);
        @(negedge clk); chk("t21_p0_eop", 256'(out_pkt_vld), 256'(2'b01));
        cyc(); out_pkt_rdy = 2'b11; in_pkt_msg = mk_msg(1'b0);
        @(negedge clk);
        chk("t21_p1_vld", 256'(out_pkt_vld), 256'(2'b10));
        chk("t21_p1_rdy", 256'(in_pkt_rdy), 256'(1));
        cyc(); in_pkt_msg = mk_msg(1'b1);
        @(negedge clk); chk("t21_p1_eop", 256'(out_pkt_vld), 256'(2'b10));
        cyc(); in_pkt_vld = 1'b0;
        @(negedge clk); chk("t21_cnt_end", 256'(ord_cnt_used), 256'(0));

        // Spurious read data with nothing outstanding
        cyc(); in_pkt_vld = 1'b1; in_pkt_msg = mk_msg(1'b1);
        @(negedge clk);
        chk("t22_in_rdy", 256'(in_pkt_rdy), 256'(0));
        chk("t22_out_vld", 256'(out_pkt_vld), 256'(0));
        chk("t22_err_pre", 256'(dbg_sig[31]), 256'(0));
        cyc(); in_pkt_vld = 1'b0;
        @(negedge clk); chk("t22_err_set", 256'(dbg_sig[31]), 256'(1));
        repeat (3) cyc();
        @(negedge clk); chk("t22_err_sticky", 256'(dbg_sig[31]), 256'(1));
        do_reset();
        @(negedge clk); chk("t22_err_clr", 256'(dbg_sig[31]), 256'(0));

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            cyc();
            in_pct      = ((i / 250) % 3 == 0) ? 10 : 60;
            rst         = ($urandom_range(0, 599) == 0);
            req_vld     = 2'($urandom());
            req_msg     = rnd_req();
            pkt_req_rdy = ($urandom_range(0, 99) < 70);
            in_pkt_vld  = ($urandom_range(0, 99) < in_pct);
            in_pkt_dat  = rnd_dat();
            in_pkt_msg  = mk_msg($urandom_range(0, 99) < 35);
            out_pkt_rdy = 2'($urandom());
        end
        cyc(); rst = 1'b0; idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
